// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bundle between a CPU's imem/dmem ports
// and the mem_responder memory model.
//
// Signals:
//   imem_read, imem_address          imem read request (master -> slave)
//   imem_resp, imem_rdata            imem response     (slave -> master)
//   dmem_read, dmem_write,
//   dmem_address, dmem_wdata,
//   dmem_wmask                       dmem request      (master -> slave)
//   dmem_resp, dmem_rdata            dmem response     (slave -> master)
//   imem_err, dmem_err               out-of-range flags, present only when
//                                    MEM_RANGE_CHECK_EN is defined
//
// Modports: master (CPU side), slave (memory side).

interface mem_responder_if;
    logic        imem_read;
    logic [31:0] imem_address;
    logic        imem_resp;
    logic [31:0] imem_rdata;

    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_address;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wmask;
    logic        dmem_resp;
    logic [31:0] dmem_rdata;

`ifdef MEM_RANGE_CHECK_EN
    logic        imem_err;
    logic        dmem_err;

    modport master (
        output imem_read, imem_address,
        input  imem_resp, imem_rdata, imem_err,
        output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_wmask,
        input  dmem_resp, dmem_rdata, dmem_err
    );

    modport slave (
        input  imem_read, imem_address,
        output imem_resp, imem_rdata, imem_err,
        input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_wmask,
        output dmem_resp, dmem_rdata, dmem_err
    );
`else
    modport master (
        output imem_read, imem_address,
        input  imem_resp, imem_rdata,
        output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_wmask,
        input  dmem_resp, dmem_rdata
    );

    modport slave (
        input  imem_read, imem_address,
        output imem_resp, imem_rdata,
        input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_wmask,
        output dmem_resp, dmem_rdata
    );
`endif
endinterface

// File: rtl/mem_responder.sv
// mem_responder: single-ported word memory serving a CPU's imem and dmem
// ports with a fixed access latency. dmem has priority, except that imem is
// granted next whenever it was passed over once (imem_owed).
//
// Parameters:
//   ADDR_W     word-index width (DEPTH = 2**ADDR_W words of 32 bits)
//   LATENCY    cycles from accept to resp, accept cycle included (1..15)
//   BASE_ADDR  byte address of word 0
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (array contents are kept)
//   bus    mem_responder_if.slave: imem/dmem request and response signals
//
// Optional feature: define MEM_RANGE_CHECK_EN to add imem_err/dmem_err.
// Out-of-range accesses then complete with err = 1 and rdata = 32'hDEAD_BEEF,
// and out-of-range writes leave the array untouched. Without the macro all
// addresses wrap modulo DEPTH.

module mem_responder #(
    parameter int          ADDR_W    = 10,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_responder_if.slave  bus
);
    localparam int         DEPTH  = 2 ** ADDR_W;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t              state_reg;
    logic [3:0]          cnt_reg;
    logic                owed_reg;
    logic                port_dmem_reg;  // granted port: 1 = dmem, 0 = imem
    logic                rd_op_reg;      // legal read in flight
    logic                illegal_reg;    // dmem read+write together
    logic                oor_reg;        // out-of-range access in flight
    logic [ADDR_W-1:0]   idx_reg;
    logic                imem_resp_reg;
    logic                dmem_resp_reg;
    logic [31:0]         imem_hold_reg;
    logic [31:0]         dmem_hold_reg;

    logic [31:0]         mem [DEPTH];
    logic [31:0]         mem_q;

    // Address decode
    logic [31:0]         imem_off;
    logic [31:0]         dmem_off;
    logic [31:0]         sel_off;
    logic [ADDR_W-1:0]   sel_idx;
    logic [ADDR_W-1:0]   rd_idx;
    logic                sel_oor;
    logic                unused_bits;

    assign imem_off    = bus.imem_address - BASE_ADDR;
    assign dmem_off    = bus.dmem_address - BASE_ADDR;
    assign unused_bits = ^{imem_off, dmem_off};

    // Arbitration
    logic dmem_pend;
    logic grant_dmem;
    logic grant_imem;
    logic write_en;

    assign dmem_pend  = bus.dmem_read | bus.dmem_write;
    assign grant_dmem = (state_reg == IDLE) && dmem_pend && !(bus.imem_read && owed_reg);
    assign grant_imem = (state_reg == IDLE) && bus.imem_read && !grant_dmem;

    assign sel_off = grant_dmem ? dmem_off : imem_off;
    assign sel_idx = sel_off[ADDR_W+1:2];

`ifdef MEM_RANGE_CHECK_EN
    // Offset wraps to a huge value below BASE_ADDR, so one compare covers both ends.
    assign sel_oor = (sel_off >> (ADDR_W + 2)) != 32'd0;
`else
    assign sel_oor = 1'b0;
`endif

    // Read+write together is treated as a write. rst_n gating keeps a
    // request that is held through reset from committing.
    assign write_en = rst_n && grant_dmem && bus.dmem_write && !sel_oor;

    // In IDLE the read port follows the incoming request so LATENCY = 1 can
    // present data in the very next cycle; otherwise it tracks the latched index.
    assign rd_idx = (state_reg == IDLE) ? sel_idx : idx_reg;

    // Array: byte-lane writes at the accept edge, registered read every cycle.
    always_ff @(posedge clk) begin
        if (write_en) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.dmem_wmask[b]) begin
                    mem[sel_idx][8*b +: 8] <= bus.dmem_wdata[8*b +: 8];
                end
            end
        end
        mem_q <= mem[rd_idx];
    end

    // Response data: only the resp cycle shows fresh data; otherwise the last
    // value presented is held.
    logic [31:0] imem_rdata_out;
    logic [31:0] dmem_rdata_out;

    always_comb begin
        imem_rdata_out = imem_hold_reg;
        if (imem_resp_reg) begin
            imem_rdata_out = oor_reg ? 32'hDEAD_BEEF : mem_q;
        end
        dmem_rdata_out = dmem_hold_reg;
        if (dmem_resp_reg) begin
            if (oor_reg) begin
                dmem_rdata_out = 32'hDEAD_BEEF;
            end else if (illegal_reg) begin
                dmem_rdata_out = 32'd0;
            end else if (rd_op_reg) begin
                dmem_rdata_out = mem_q;
            end
        end
    end

    assign bus.imem_resp  = imem_resp_reg;
    assign bus.dmem_resp  = dmem_resp_reg;
    assign bus.imem_rdata = imem_rdata_out;
    assign bus.dmem_rdata = dmem_rdata_out;
`ifdef MEM_RANGE_CHECK_EN
    assign bus.imem_err   = imem_resp_reg & oor_reg;
    assign bus.dmem_err   = dmem_resp_reg & oor_reg;
`endif

    // Control FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            owed_reg      <= 1'b0;
            port_dmem_reg <= 1'b0;
            rd_op_reg     <= 1'b0;
            illegal_reg   <= 1'b0;
            oor_reg       <= 1'b0;
            idx_reg       <= '0;
            imem_resp_reg <= 1'b0;
            dmem_resp_reg <= 1'b0;
            imem_hold_reg <= 32'd0;
            dmem_hold_reg <= 32'd0;
        end else begin
            imem_resp_reg <= 1'b0;
            dmem_resp_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant_dmem || grant_imem) begin
                        port_dmem_reg <= grant_dmem;
                        rd_op_reg     <= grant_dmem ? (bus.dmem_read & ~bus.dmem_write) : 1'b1;
                        illegal_reg   <= grant_dmem & bus.dmem_read & bus.dmem_write;
                        oor_reg       <= sel_oor;
                        idx_reg       <= sel_idx;
                        cnt_reg       <= LAT_M1;
                        if (grant_dmem && bus.imem_read) begin
                            owed_reg <= 1'b1;
                        end else if (grant_imem) begin
                            owed_reg <= 1'b0;
                        end
                        if (LATENCY == 1) begin
                            state_reg     <= RESP;
                            imem_resp_reg <= grant_imem;
                            dmem_resp_reg <= grant_dmem;
                        end else begin
                            state_reg <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt_reg <= cnt_reg - 4'd1;
                    if (cnt_reg == 4'd1) begin
                        state_reg     <= RESP;
                        imem_resp_reg <= ~port_dmem_reg;
                        dmem_resp_reg <= port_dmem_reg;
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                    if (port_dmem_reg) begin
                        dmem_hold_reg <= dmem_rdata_out;
                    end else begin
                        imem_hold_reg <= imem_rdata_out;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed self-checking bench for mem_responder.
// dut_a runs with LATENCY = 2, dut_b with LATENCY = 1; both share clk/rst_n.
// Build with MEM_RANGE_CHECK_EN defined to exercise the err outputs.

module tb_mem_responder;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    mem_responder_if bus_a ();
    mem_responder_if bus_b ();

    mem_responder #(.ADDR_W(10), .LATENCY(2), .BASE_ADDR(32'h4000_0000)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    mem_responder #(.ADDR_W(10), .LATENCY(1), .BASE_ADDR(32'h4000_0000)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_req(input int d, input bit is_i, input bit rd, input bit wr,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] mask);
        if (d == 0) begin
            if (is_i) begin
                bus_a.imem_read = rd; bus_a.imem_address = addr;
            end else begin
                bus_a.dmem_read = rd; bus_a.dmem_write = wr; bus_a.dmem_address = addr;
                bus_a.dmem_wdata = wdata; bus_a.dmem_wmask = mask;
            end
        end else begin
            if (is_i) begin
                bus_b.imem_read = rd; bus_b.imem_address = addr;
            end else begin
                bus_b.dmem_read = rd; bus_b.dmem_write = wr; bus_b.dmem_address = addr;
                bus_b.dmem_wdata = wdata; bus_b.dmem_wmask = mask;
            end
        end
    endtask

    function automatic logic get_resp(input int d, input bit is_i);
        if (d == 0) return is_i ? bus_a.imem_resp : bus_a.dmem_resp;
        return is_i ? bus_b.imem_resp : bus_b.dmem_resp;
    endfunction

    function automatic logic [31:0] get_rdata(input int d, input bit is_i);
        if (d == 0) return is_i ? bus_a.imem_rdata : bus_a.dmem_rdata;
        return is_i ? bus_b.imem_rdata : bus_b.dmem_rdata;
    endfunction

    function automatic logic get_err(input int d, input bit is_i);
`ifdef MEM_RANGE_CHECK_EN
        if (d == 0) return is_i ? bus_a.imem_err : bus_a.dmem_err;
        return is_i ? bus_b.imem_err : bus_b.dmem_err;
`else
        return (d < 0) && is_i;
`endif
    endfunction

    // One request: present at a negedge, wait (bounded) for resp, then drop it.
    // lat = number of rising edges from accept to resp (-1 on timeout);
    // after = resp level one cycle after the pulse.
    task automatic txn(input int d, input bit is_i, input bit rd, input bit wr,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] mask, output int lat,
                       output logic [31:0] rdata, output logic err, output logic after);
        lat = -1; rdata = 32'd0; err = 1'b0;
        @(negedge clk);
        set_req(d, is_i, rd, wr, addr, wdata, mask);
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (get_resp(d, is_i)) begin
                lat = c; rdata = get_rdata(d, is_i); err = get_err(d, is_i);
                break;
            end
        end
        @(negedge clk);
        set_req(d, is_i, 1'b0, 1'b0, addr, wdata, mask);
        @(posedge clk); #1;
        after = get_resp(d, is_i);
        $display("txn dut=%0d %s rd=%0b wr=%0b addr=%h wdata=%h mask=%b lat=%0d rdata=%h err=%0b",
                 d, is_i ? "imem" : "dmem", rd, wr, addr, wdata, mask, lat, rdata, err);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        set_req(0, 1, 0, 0, 32'h0, 32'h0, 4'h0); set_req(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        set_req(1, 1, 0, 0, 32'h0, 32'h0, 4'h0); set_req(1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus_a.imem_resp !== 1'b0) begin failures++; $display("FAIL reset_imem_resp: got %b expected 0", bus_a.imem_resp); end
        checks++; if (bus_a.dmem_resp !== 1'b0) begin failures++; $display("FAIL reset_dmem_resp: got %b expected 0", bus_a.dmem_resp); end
        checks++; if (bus_a.imem_rdata !== 32'd0) begin failures++; $display("FAIL reset_imem_rdata: got %h expected 0", bus_a.imem_rdata); end
        checks++; if (bus_a.dmem_rdata !== 32'd0) begin failures++; $display("FAIL reset_dmem_rdata: got %h expected 0", bus_a.dmem_rdata); end
        checks++; if (bus_b.imem_resp !== 1'b0 || bus_b.dmem_resp !== 1'b0) begin failures++; $display("FAIL reset_b_resp: got %b%b expected 00", bus_b.imem_resp, bus_b.dmem_resp); end
        $display("reset: outputs checked");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write_read;
        int lat; logic [31:0] rd; logic er; logic af;
        txn(0, 0, 0, 1, 32'h4000_0010, 32'hCAFE_F00D, 4'hF, lat, rd, er, af);
        checks++; if (lat != 2) begin failures++; $display("FAIL wr_latency: got %0d expected 2", lat); end
        checks++; if (rd !== 32'd0) begin failures++; $display("FAIL wr_rdata_unchanged: got %h expected 00000000", rd); end
        checks++; if (af !== 1'b0) begin failures++; $display("FAIL wr_resp_one_cycle: got %b expected 0", af); end
        txn(0, 0, 1, 0, 32'h4000_0010, 32'h0, 4'h0, lat, rd, er, af);
        checks++; if (lat != 2) begin failures++; $display("FAIL rd_latency: got %0d expected 2", lat); end
        checks++; if (rd !== 32'hCAFE_F00D) begin failures++; $display("FAIL rd_data: got %h expected cafef00d", rd); end
        checks++; if (af !== 1'b0) begin failures++; $display("FAIL rd_resp_one_cycle: got %b expected 0", af); end
    endtask

    task automatic test_partial_write;
        int lat; logic [31:0] rd; logic er; logic af;
        txn(0, 0, 0, 1, 32'h4000_0020, 32'h1122_3344, 4'hF, lat, rd, er, af);
        txn(0, 0, 0, 1, 32'h4000_0020, 32'hAABB_CCDD, 4'b0101, lat, rd, er, af);
        txn(0, 0, 1, 0, 32'h4000_0020, 32'h0, 4'h0, lat, rd, er, af);
        checks++; if (rd !== 32'h11BB_33DD) begin failures++; $display("FAIL partial_mask: got %h expected 11bb33dd", rd); end
        txn(0, 0, 0, 1, 32'h4000_0020, 32'hFFFF_FFFF, 4'b0000, lat, rd, er, af);
        checks++; if (lat != 2) begin failures++; $display("FAIL zero_mask_latency: got %0d expected 2", lat); end
        txn(0, 0, 1, 0, 32'h4000_0023, 32'h0, 4'h0, lat, rd, er, af);
        checks++; if (rd !== 32'h11BB_33DD) begin failures++; $display("FAIL zero_mask_lowbits: got %h expected 11bb33dd", rd); end
        txn(0, 1, 1, 0, 32'h4000_0020, 32'h0, 4'h0, lat, rd, er, af);
        checks++; if (lat != 2) begin failures++; $display("FAIL imem_latency: got %0d expected 2", lat); end
        checks++; if (rd !== 32'h11BB_33DD) begin failures++; $display("FAIL imem_data: got %h expected 11bb33dd", rd); end
    endtask

    task automatic test_illegal;
        int lat; logic [31:0] rd; logic er; logic af;
        txn(0, 0, 1, 1, 32'h4000_0030, 32'h0000_0055, 4'hF, lat, rd, er, af);
        checks++; if (lat != 2) begin failures++; $display("FAIL illegal_latency: got %0d expected 2", lat); end
        checks++; if (rd !== 32'd0) begin failures++; $display("FAIL illegal_rdata: got %h expected 00000000", rd); end
        txn(0, 0, 1, 0, 32'h4000_0030, 32'h0, 4'h0, lat, rd, er, af);
        checks++; if (rd !== 32'h0000_0055) begin failures++; $display("FAIL illegal_as_write: got %h expected 00000055", rd); end
    endtask

    task automatic test_arbitration;
        int lat; logic [31:0] rd; logic er; logic af;
        logic [12:1] exp_d;
        logic [12:1] exp_i;
        txn(0, 0, 0, 1, 32'h4000_0040, 32'hD0D0_0001, 4'hF, lat, rd, er, af);
        txn(0, 0, 0, 1, 32'h4000_0044, 32'h1010_0002, 4'hF, lat, rd, er, af);
        exp_d = 12'b0000_1000_0010;   // dmem resp after edges 2 and 8
        exp_i = 12'b0100_0001_0000;   // imem resp after edges 5 and 11
        @(negedge clk);
        bus_a.imem_read = 1'b1; bus_a.imem_address = 32'h4000_0044;
        bus_a.dmem_read = 1'b1; bus_a.dmem_write = 1'b0; bus_a.dmem_address = 32'h4000_0040;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            $display("arb cycle=%0d imem_resp=%b dmem_resp=%b", k, bus_a.imem_resp, bus_a.dmem_resp);
            checks++;
            if (bus_a.dmem_resp !== exp_d[k] || bus_a.imem_resp !== exp_i[k]) begin
                failures++;
                $display("FAIL arb_cycle%0d: got d=%b i=%b expected d=%b i=%b", k,
                         bus_a.dmem_resp, bus_a.imem_resp, exp_d[k], exp_i[k]);
            end
            if (exp_d[k]) begin
                checks++;
                if (bus_a.dmem_rdata !== 32'hD0D0_0001) begin failures++; $display("FAIL arb_dmem_data: got %h expected d0d00001", bus_a.dmem_rdata); end
            end
            if (exp_i[k]) begin
                checks++;
                if (bus_a.imem_rdata !== 32'h1010_0002) begin failures++; $display("FAIL arb_imem_data: got %h expected 10100002", bus_a.imem_rdata); end
            end
        end
        @(negedge clk);
        bus_a.imem_read = 1'b0; bus_a.dmem_read = 1'b0;
    endtask

    task automatic test_reset_mid;
        int lat; logic [31:0] rd; logic er; logic af; logic seen;
        seen = 1'b0;
        @(negedge clk);
        bus_a.dmem_read = 1'b1; bus_a.dmem_write = 1'b0; bus_a.dmem_address = 32'h4000_0010;
        @(posedge clk); #1;           // accepted, now in WAIT
        rst_n = 1'b0;
        #1;
        checks++; if (bus_a.dmem_rdata !== 32'd0) begin failures++; $display("FAIL async_dmem_rdata: got %h expected 0", bus_a.dmem_rdata); end
        checks++; if (bus_a.imem_rdata !== 32'd0) begin failures++; $display("FAIL async_imem_rdata: got %h expected 0", bus_a.imem_rdata); end
        repeat (3) begin
            @(posedge clk); #1;
            if (bus_a.dmem_resp !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_resp: got resp=1 expected 0"); end
        @(negedge clk);
        bus_a.dmem_read = 1'b0;
        rst_n = 1'b1;
        $display("reset mid-access: released");
        txn(0, 0, 1, 0, 32'h4000_0010, 32'h0, 4'h0, lat, rd, er, af);
        checks++; if (lat != 2) begin failures++; $display("FAIL post_reset_latency: got %0d expected 2", lat); end
        checks++; if (rd !== 32'hCAFE_F00D) begin failures++; $display("FAIL post_reset_data: got %h expected cafef00d", rd); end
    endtask

    task automatic test_latency1;
        int lat; logic [31:0] rd; logic er; logic af;
        txn(1, 0, 0, 1, 32'h4000_0000, 32'h0123_4567, 4'hF, lat, rd, er, af);
        checks++; if (lat != 1) begin failures++; $display("FAIL l1_write_latency: got %0d expected 1", lat); end
        txn(1, 0, 0, 1, 32'h4000_0004, 32'h89AB_CDEF, 4'hF, lat, rd, er, af);
        @(negedge clk);
        bus_b.imem_read = 1'b1; bus_b.imem_address = 32'h4000_0000;
        @(posedge clk); #1;
        $display("l1 imem addr=40000000 resp=%b rdata=%h", bus_b.imem_resp, bus_b.imem_rdata);
        checks++; if (bus_b.imem_resp !== 1'b1) begin failures++; $display("FAIL l1_first_resp: got %b expected 1", bus_b.imem_resp); end
        checks++; if (bus_b.imem_rdata !== 32'h0123_4567) begin failures++; $display("FAIL l1_first_data: got %h expected 01234567", bus_b.imem_rdata); end
        @(negedge clk);
        bus_b.imem_address = 32'h4000_0004;
        @(posedge clk); #1;
        checks++; if (bus_b.imem_resp !== 1'b0) begin failures++; $display("FAIL l1_gap: got %b expected 0", bus_b.imem_resp); end
        @(posedge clk); #1;
        $display("l1 imem addr=40000004 resp=%b rdata=%h", bus_b.imem_resp, bus_b.imem_rdata);
        checks++; if (bus_b.imem_resp !== 1'b1) begin failures++; $display("FAIL l1_second_resp: got %b expected 1", bus_b.imem_resp); end
        checks++; if (bus_b.imem_rdata !== 32'h89AB_CDEF) begin failures++; $display("FAIL l1_second_data: got %h expected 89abcdef", bus_b.imem_rdata); end
        @(negedge clk);
        bus_b.imem_read = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus_b.imem_resp !== 1'b0) begin failures++; $display("FAIL l1_resp_drop: got %b expected 0", bus_b.imem_resp); end
    endtask

    task automatic test_range;
        int lat; logic [31:0] rd; logic er; logic af;
        txn(0, 0, 0, 1, 32'h4000_0000, 32'hA5A5_A5A5, 4'hF, lat, rd, er, af);
        txn(0, 0, 0, 1, 32'h4000_1000, 32'h1234_5678, 4'hF, lat, rd, er, af);
        checks++; if (lat != 2) begin failures++; $display("FAIL range_wr_latency: got %0d expected 2", lat); end
`ifdef MEM_RANGE_CHECK_EN
        checks++; if (er !== 1'b1) begin failures++; $display("FAIL range_wr_err: got %b expected 1", er); end
        checks++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL range_wr_rdata: got %h expected deadbeef", rd); end
        txn(0, 0, 1, 0, 32'h4000_0000, 32'h0, 4'h0, lat, rd, er, af);
        checks++; if (rd !== 32'hA5A5_A5A5) begin failures++; $display("FAIL range_word0_kept: got %h expected a5a5a5a5", rd); end
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL range_rd_err: got %b expected 0", er); end
`else
        txn(0, 0, 1, 0, 32'h4000_0000, 32'h0, 4'h0, lat, rd, er, af);
        checks++; if (rd !== 32'h1234_5678) begin failures++; $display("FAIL wrap_word0: got %h expected 12345678", rd); end
        txn(0, 0, 1, 0, 32'h4000_1020, 32'h0, 4'h0, lat, rd, er, af);
        checks++; if (rd !== 32'h11BB_33DD) begin failures++; $display("FAIL wrap_word8: got %h expected 11bb33dd", rd); end
`endif
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_write_read();
        test_partial_write();
        test_illegal();
        test_arbitration();
        test_reset_mid();
        test_latency1();
        test_range();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
